// File: rtl/tdc_pkg.sv
// tdc_pkg: shared header constant, frame FSM encoding and byte-counter sizing
package tdc_pkg;
    localparam logic [7:0] TDC_HDR = 8'hA0;
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, WAIT} state_t;
    function automatic int bcnt_w(input int nbytes);
        return $clog2(nbytes + 1);
    endfunction
endpackage

// File: rtl/tdc_stream_packer_if.sv
// tdc_stream_packer_if: TDC write side plus byte-serial transmit side of the packer
interface tdc_stream_packer_if #(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 48
);
    logic [CHANNELS-1:0]            wr_en;
    logic [CHANNELS*DATA_WIDTH-1:0] din;
    logic                           tx_busy;
    logic [7:0]                     tx_data;
    logic                           new_tx_data;
    logic                           frame_done;
    modport master (output wr_en, din, tx_busy, input tx_data, new_tx_data, frame_done);
    modport slave  (input wr_en, din, tx_busy, output tx_data, new_tx_data, frame_done);
endinterface

// File: rtl/tdc_sync_fifo.sv
// tdc_sync_fifo: single-clock FIFO, writes on full are dropped, reads on empty ignored
module tdc_sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [AW:0]      cnt_q;
    logic             push, pop;
    assign push    = wr_en_i & ~full_o;
    assign pop     = rd_en_i & ~empty_o;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign dout_o  = mem_q[rp_q];
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= din_i;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wp_q <= wp_q + AW'(1);
            if (pop) rp_q <= rp_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/tdc_stream_packer.sv
// tdc_stream_packer: round-robin drains per-channel TDC FIFOs into header+MSB-first byte frames
module tdc_stream_packer
    import tdc_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 48,
    parameter int DEPTH      = 16
) (
    input  logic                clk,
    input  logic                rst,
    tdc_stream_packer_if.slave  bus,
    input  logic                enable,
    input  logic                clear_overflow,
    output logic [CHANNELS-1:0] empty,
    output logic [CHANNELS-1:0] full,
    output logic [CHANNELS-1:0] overflow
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int CW = (CHANNELS < 2) ? 1 : $clog2(CHANNELS);
    localparam int BW = bcnt_w(NB);
    state_t                state_q, state_d;
    logic [CW-1:0]         ch_q, ch_d, nxt_q, nxt_d, gnt;
    logic                  gnt_ok, last;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [7:0]            tx_q, byte_now;
    logic [CHANNELS-1:0]   rd_en, ovf_q;
    logic [DATA_WIDTH-1:0] dout [CHANNELS];
    int                    rr_idx;
    genvar k;
    for (k = 0; k < CHANNELS; k++) begin : g_ch
        tdc_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en_i (bus.wr_en[k]),
            .din_i   (bus.din[k*DATA_WIDTH +: DATA_WIDTH]),
            .rd_en_i (rd_en[k]),
            .dout_o  (dout[k]),
            .empty_o (empty[k]),
            .full_o  (full[k])
        );
    end
    // descending scan so the channel closest after nxt_q wins
    always_comb begin
        gnt    = '0;
        gnt_ok = 1'b0;
        rr_idx = 0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            rr_idx = int'(nxt_q) + i;
            if (rr_idx >= CHANNELS) rr_idx = rr_idx - CHANNELS;
            if (!empty[CW'(rr_idx)]) begin
                gnt    = CW'(rr_idx);
                gnt_ok = 1'b1;
            end
        end
    end
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        nxt_d    = nxt_q;
        bcnt_d   = bcnt_q;
        sh_d     = sh_q;
        rd_en    = '0;
        last     = bcnt_q == BW'(NB);
        byte_now = (state_q == HEADER) ? (TDC_HDR | {4'h0, 4'(ch_q)}) : sh_q[DATA_WIDTH-1 -: 8];
        case (state_q)
            IDLE: if (enable && gnt_ok) begin
                rd_en[gnt] = 1'b1;
                sh_d       = dout[gnt];
                ch_d       = gnt;
                nxt_d      = (gnt == CW'(CHANNELS - 1)) ? '0 : gnt + CW'(1);
                bcnt_d     = '0;
                state_d    = HEADER;
            end
            HEADER: if (!bus.tx_busy) state_d = WAIT;
            PAYLOAD: if (!bus.tx_busy) begin
                sh_d    = sh_q << 8;
                bcnt_d  = bcnt_q + BW'(1);
                state_d = WAIT;
            end
            default: state_d = last ? IDLE : PAYLOAD;
        endcase
    end
    assign bus.new_tx_data = ~rst & ~bus.tx_busy & (state_q == HEADER || state_q == PAYLOAD);
    assign bus.tx_data     = bus.new_tx_data ? byte_now : tx_q;
    assign bus.frame_done  = ~rst & (state_q == WAIT) & last;
    assign overflow        = ovf_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            nxt_q   <= '0;
            bcnt_q  <= '0;
            sh_q    <= '0;
            tx_q    <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            nxt_q   <= nxt_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            if (bus.new_tx_data) tx_q <= byte_now;
            ovf_q   <= (bus.wr_en & full) | (ovf_q & ~{CHANNELS{clear_overflow}});
        end
    end
endmodule

// File: tb/tb_tdc_stream_packer.sv
// tb_tdc_stream_packer: directed checks of framing, round-robin, FIFO limits, busy stalls and reset
module tb_tdc_stream_packer;
    logic       clk = 1'b0;
    logic       rst, enable, clear_overflow;
    logic [1:0] empty, full, overflow;
    int         n_cmp = 0, n_bad = 0;
    int         cyc = 0, fd_cnt = 0, fd_cyc = 0, c0 = 0;
    logic [7:0] q_b[$];
    int         q_c[$];
    logic [7:0] e34 [7] = '{8'hA1, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

    tdc_stream_packer_if #(.CHANNELS(2), .DATA_WIDTH(48)) bus ();

    tdc_stream_packer #(.CHANNELS(2), .DATA_WIDTH(48), .DEPTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .enable         (enable),
        .clear_overflow (clear_overflow),
        .empty          (empty),
        .full           (full),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.new_tx_data) begin
            q_b.push_back(bus.tx_data);
            q_c.push_back(cyc);
        end
        if (bus.frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (bus.tx_busy) begin
            n_cmp++;
            assert (bus.new_tx_data === 1'b0) else begin
                n_bad++;
                $error("FAIL strobe_while_busy: got %0b want 0", bus.new_tx_data);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] en, input logic [47:0] d0, input logic [47:0] d1);
        bus.wr_en = en;
        bus.din   = {d1, d0};
        @(posedge clk); #1;
        bus.wr_en = '0;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic clr();
        q_b.delete();
        q_c.delete();
        fd_cnt = 0;
    endtask

    task automatic wait_fd(input int target, input int budget);
        for (int i = 0; i < budget && fd_cnt < target; i++) begin
            @(negedge clk); #1;
        end
        chk("frame_done_cnt", 64'(fd_cnt), 64'(target));
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int i = 0; i < budget && q_b.size() < n; i++) begin
            @(negedge clk); #1;
        end
        chk("byte_cnt", 64'(q_b.size()), 64'(n));
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clear_overflow = 1'b0;
        bus.wr_en = '0; bus.din = '0; bus.tx_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_empty", empty, 2'b11);
        chk("rst_full", full, 2'b00);
        chk("rst_ovf", overflow, 2'b00);
        chk("rst_txd", bus.tx_data, 8'h00);
        chk("rst_strobe", bus.new_tx_data, 1'b0);
        chk("rst_fd", bus.frame_done, 1'b0);

        // single frame on ch1
        wr(2'b10, 48'h0, 48'h123456789ABC);
        @(negedge clk);
        chk("wr_visible", empty, 2'b01);
        clr();
        c0 = cyc;
        enable = 1'b1;
        wait_fd(1, 40);
        enable = 1'b0;
        chk("f1_nbytes", 64'(q_b.size()), 7);
        for (int i = 0; i < 7; i++) chk("f1_byte", q_b[i], e34[i]);
        for (int i = 0; i < 7; i++) chk("f1_time", 64'(q_c[i]), 64'(c0 + 1 + 2*i));
        chk("f1_fd_time", 64'(fd_cyc), 64'(c0 + 14));
        chk("tx_hold", bus.tx_data, 8'hBC);
        chk("f1_drained", empty, 2'b11);

        // fill ch0 to full, overflow and its clearing
        for (int i = 0; i < 15; i++) wr(2'b01, 48'(100 + i), 48'h0);
        @(negedge clk);
        chk("full15", full, 2'b00);
        wr(2'b01, 48'd115, 48'h0);
        @(negedge clk);
        chk("full16", full, 2'b01);
        chk("ovf16", overflow, 2'b00);
        wr(2'b01, 48'hDEAD, 48'h0);
        @(negedge clk);
        chk("ovf17", overflow, 2'b01);
        chk("full17", full, 2'b01);
        clear_overflow = 1'b1;
        wr(2'b01, 48'hBEEF, 48'h0);
        clear_overflow = 1'b0;
        @(negedge clk);
        chk("clr_coincide", overflow, 2'b01);
        clear_overflow = 1'b1;
        @(posedge clk); #1;
        clear_overflow = 1'b0;
        @(negedge clk);
        chk("clr_ovf", overflow, 2'b00);
        clr();
        enable = 1'b1;
        wait_fd(1, 40);
        enable = 1'b0;
        chk("fifo_order_hdr", q_b[0], 8'hA0);
        chk("fifo_order_lsb", q_b[6], 8'h64);
        do_rst();

        // round robin across both channels
        wr(2'b11, 48'hC0, 48'hC1);
        wr(2'b11, 48'hC2, 48'hC3);
        clr();
        enable = 1'b1;
        wait_fd(4, 200);
        enable = 1'b0;
        chk("rr_nbytes", 64'(q_b.size()), 28);
        chk("rr_hdr0", q_b[0], 8'hA0);
        chk("rr_hdr1", q_b[7], 8'hA1);
        chk("rr_hdr2", q_b[14], 8'hA0);
        chk("rr_hdr3", q_b[21], 8'hA1);
        chk("rr_pl0", q_b[6], 8'hC0);
        chk("rr_pl1", q_b[13], 8'hC1);
        chk("rr_pl2", q_b[20], 8'hC2);
        chk("rr_pl3", q_b[27], 8'hC3);
        do_rst();

        // tx_busy stall in the payload
        wr(2'b01, 48'h010203040506, 48'h0);
        clr();
        enable = 1'b1;
        wait_bytes(2, 20);
        @(posedge clk); #1;
        bus.tx_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("busy_hold", 64'(q_b.size()), 2);
        bus.tx_busy = 1'b0;
        c0 = cyc;
        @(negedge clk); #1;
        chk("resume_cycle", 64'(q_c[2]), 64'(c0));
        chk("resume_byte", q_b[2], 8'h02);
        wait_fd(1, 40);
        enable = 1'b0;
        chk("busy_nbytes", 64'(q_b.size()), 7);
        chk("busy_last", q_b[6], 8'h06);
        do_rst();

        // reset in the middle of a frame
        for (int i = 0; i < 17; i++) wr(2'b10, 48'h0, 48'(i));
        @(negedge clk);
        chk("pre_ovf", overflow, 2'b10);
        wr(2'b01, 48'hAABBCCDDEEFF, 48'h0);
        clr();
        enable = 1'b1;
        wait_bytes(3, 20);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_nbytes", 64'(q_b.size()), 3);
        chk("abort_b2", q_b[2], 8'hBB);
        chk("abort_empty", empty, 2'b11);
        chk("abort_full", full, 2'b00);
        chk("abort_ovf", overflow, 2'b00);
        enable = 1'b0;

        // enable dropped during the header
        wr(2'b01, 48'h111111111111, 48'h0);
        wr(2'b01, 48'h222222222222, 48'h0);
        clr();
        enable = 1'b1;
        wait_bytes(1, 20);
        enable = 1'b0;
        wait_fd(1, 40);
        repeat (20) @(negedge clk);
        chk("hold_nbytes", 64'(q_b.size()), 7);
        chk("hold_empty", empty, 2'b10);
        chk("hold_b1", q_b[1], 8'h11);
        enable = 1'b1;
        wait_fd(2, 40);
        enable = 1'b0;
        chk("resume_nbytes", 64'(q_b.size()), 14);
        chk("resume_hdr", q_b[7], 8'hA0);
        chk("resume_b1", q_b[8], 8'h22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tdc_stream_packer.md
TDC_STREAM_PACKER -- requirements
Module: tdc_stream_packer

Interface
REQ-001 Parameter CHANNELS, default 2, number of independent TDC result input channels (1..16) SHALL be supported.
REQ-002 Parameter DATA_WIDTH, default 48, result word width in bits, SHALL be a multiple of 8 (8..64).
REQ-003 Parameter DEPTH, default 16, per-channel FIFO depth in words, SHALL be a power of 2 (2..256).
REQ-004 The block SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-005 clk  input  1  system clock, 50 MHz.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 wr_en  input  CHANNELS  per-channel write strobe, one word per high cycle.
REQ-008 din  input  CHANNELS*DATA_WIDTH  channel k data in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 enable  input  1  permits new frames to start.
REQ-010 clear_overflow  input  1  one-cycle pulse that clears all overflow flags.
REQ-011 tx_busy  input  1  serial transmitter busy or blocked.
REQ-012 tx_data  output  8  byte to serial transmitter.
REQ-013 new_tx_data  output  1  one-cycle strobe qualifying tx_data.
REQ-014 empty  output  CHANNELS  per-channel FIFO empty.
REQ-015 full  output  CHANNELS  per-channel FIFO full.
REQ-016 overflow  output  CHANNELS  sticky flag: a write was dropped on a full FIFO.
REQ-017 frame_done  output  1  one-cycle pulse after the last byte of a frame is issued.

Function
REQ-018 Each channel SHALL have its own FIFO of DEPTH words; a write with full[k]=0 SHALL be stored and visible (empty[k]=0) the next cycle.
REQ-019 A write with full[k]=1 SHALL be dropped and set overflow[k] the next cycle, even if a pop occurs in the same cycle.
REQ-020 Simultaneous write and pop on a non-full channel SHALL keep occupancy unchanged; pointers SHALL wrap modulo DEPTH.
REQ-021 The state machine SHALL use states IDLE, HEADER, PAYLOAD, WAIT.
REQ-022 IDLE: when enable=1 and any empty[k]=0, grant SHALL go round-robin starting after the last-served channel (channel 0 first after reset); the granted word SHALL be popped into a shift register and the FSM SHALL go to HEADER.
REQ-023 HEADER: when tx_busy=0, the block SHALL drive tx_data = 0xA0 | channel index (4 bits) with new_tx_data=1 for one cycle, then go to WAIT.
REQ-024 PAYLOAD: when tx_busy=0, the block SHALL issue the next word byte, MSB first, for DATA_WIDTH/8 bytes, going to WAIT after each byte.
REQ-025 WAIT SHALL last exactly one cycle before tx_busy is sampled again; after the last payload byte, WAIT SHALL go to IDLE and pulse frame_done.
REQ-026 new_tx_data SHALL never be asserted in a cycle where tx_busy=1; tx_data SHALL hold its value between strobes.
REQ-027 Deasserting enable mid-frame SHALL let the current frame complete, after which no new frame SHALL start.
REQ-028 Minimum frame length SHALL be 2*(1+DATA_WIDTH/8) cycles with tx_busy held low.
REQ-029 clear_overflow SHALL clear all flags; if it coincides with a dropped write, that flag SHALL remain set.

Reset
REQ-030 On rst=1 at a clock edge, the block SHALL empty all FIFOs, set FSM=IDLE, set the round-robin pointer to channel 0, and drive new_tx_data=0, frame_done=0, tx_data=0x00, overflow=0, empty=all 1, full=all 0.
REQ-031 Reset mid-frame SHALL abort the frame with no further strobes; FIFO contents SHALL be discarded.

Structure
REQ-032 The header constant 0xA0, state encoding and byte-count width function SHALL reside in a shared package, tdc_pkg.
REQ-033 Per-channel storage SHALL be one sub-module, tdc_sync_fifo (parameters WIDTH, DEPTH), instantiated CHANNELS times.

Verification
REQ-034 CHANNELS=2, DATA_WIDTH=48: write 0x123456789ABC on ch1, tx_busy=0 -> bytes A1,12,34,56,78,9A,BC, each strobe separated by one cycle, then frame_done.
REQ-035 Write 17 words to ch0 with DEPTH=16 and enable=0 -> full[0]=1 after 16 writes, overflow[0]=1 after the 17th; clear_overflow -> overflow[0]=0.
REQ-036 Load ch0 and ch1 with 2 words each, enable=1 -> header order A0,A1,A0,A1.
REQ-037 Hold tx_busy=1 for 10 cycles during PAYLOAD -> no strobe while busy; the next byte is issued on the first cycle with tx_busy=0.
REQ-038 Assert rst after the 3rd byte -> no further strobes; empty=all 1, overflow=0.
REQ-039 Drop enable during HEADER with 2 words queued -> the current frame completes and the second frame does not start until enable=1.
